// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, shared prescaled tick, and per-bit
// interval debounce producing clean levels plus registered press/release/change strobes.
module btn_debouncer #(
  parameter int NIN    = 8,
  parameter int LGTICK = 16,
  parameter int NTICKS = 10
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic [NIN-1:0] i_btn,
  output logic [NIN-1:0] o_btn,
  output logic [NIN-1:0] o_press,
  output logic [NIN-1:0] o_release,
  output logic           o_change
);

  localparam int CW = (NTICKS > 1) ? $clog2(NTICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NTICKS - 1);

  logic [NIN-1:0] meta_p0;
  logic [NIN-1:0] sync_p1;
  logic           tick;
  logic [CW-1:0]  cnt [NIN];
  logic [NIN-1:0] differ;
  logic [NIN-1:0] flip;

  // Stage p0/p1: two-flop synchroniser; nothing downstream looks at i_btn directly
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= i_btn;
      sync_p1 <= meta_p0;
    end
  end

  generate
    if (LGTICK > 0) begin : g_prescale
      logic [LGTICK-1:0] pre;

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          pre <= '0;
        end else begin
          pre <= pre + 1'b1;
        end
      end

      assign tick = &pre;
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  always_comb begin
    differ = sync_p1 ^ o_btn;
    flip   = '0;
    for (int i = 0; i < NIN; i++) begin
      flip[i] = differ[i] & tick & (cnt[i] == CNT_LAST);
    end
  end

  // Any agreeing cycle restarts the interval, so a bounce costs a full re-qualification
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NIN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (!differ[i] || flip[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stage p2: level and strobes registered together so they line up for the consumer
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_btn     <= '0;
      o_press   <= '0;
      o_release <= '0;
      o_change  <= 1'b0;
    end else begin
      o_btn     <= o_btn ^ flip;
      o_press   <= flip & sync_p1;
      o_release <= flip & ~sync_p1;
      o_change  <= |flip;
    end
  end

endmodule

// File: tb/tb_btn_debouncer.sv
// Randomised and directed bench for btn_debouncer with an interval-counting reference
// model feeding an event scoreboard that a separate monitor drains.
module tb_btn_debouncer;

  localparam int NIN    = 8;
  localparam int LGTICK = 2;
  localparam int NT     = 4;
  localparam int P      = 1 << LGTICK;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NIN-1:0] btn = '0;
  logic [NIN-1:0] o_btn, o_press, o_release;
  logic           o_change;

  btn_debouncer #(.NIN(NIN), .LGTICK(LGTICK), .NTICKS(NT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_btn(btn),
    .o_btn(o_btn), .o_press(o_press), .o_release(o_release), .o_change(o_change)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [NIN-1:0] press;
    logic [NIN-1:0] rel;
  } ev_t;

  ev_t            q[$];
  int             checks = 0;
  int             errors = 0;
  int             n = 0;
  logic [NIN-1:0] mlvl = '0;
  logic [NIN-1:0] h1 = '0, h2 = '0;
  int             since [NIN];
  bit             mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Reference: a bit flips on the tick edge at which its current uninterrupted
  // disagreement run has spanned NT tick edges; tick edges are edges n with n%P==0.
  initial begin
    logic [NIN-1:0] s, pm, rm;
    for (int i = 0; i < NIN; i++) since[i] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 0; h1 = '0; h2 = '0; mlvl = '0;
        for (int i = 0; i < NIN; i++) since[i] = 0;
        q.delete();
      end else begin
        n++;
        s = h2;
        pm = '0; rm = '0;
        for (int i = 0; i < NIN; i++) begin
          if (s[i] == mlvl[i]) begin
            since[i] = 0;
          end else begin
            if (since[i] == 0) since[i] = n;
            if ((n % P == 0) && (n / P - (since[i] - 1) / P) >= NT) begin
              if (s[i]) pm[i] = 1'b1; else rm[i] = 1'b1;
              mlvl[i] = s[i];
              since[i] = 0;
            end
          end
        end
        if ((pm | rm) != '0) q.push_back('{n, pm, rm});
        h2 = h1;
        h1 = btn;
      end
    end
  end

  // Monitor: compares DUT outputs each cycle against the scoreboard head
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        chk("level", o_btn, mlvl);
        if (q.size() > 0 && q[0].cyc == n) begin
          e = q.pop_front();
          chk("change_on_flip", o_change, 1);
          chk("press_mask", o_press, e.press);
          chk("release_mask", o_release, e.rel);
        end else begin
          chk("change_idle", o_change, 0);
          chk("press_idle", o_press, 0);
          chk("release_idle", o_release, 0);
        end
      end
    end
  end

  task automatic wait_bit(input int b, input logic val, input int budget, output int m);
    m = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (o_btn[b] === val) begin
        m = n;
        return;
      end
    end
    chk("wait_bit_timeout", o_btn[b], val);
  endtask

  initial begin
    int k, m, ticks;
    #200000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m, ticks;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_btn", o_btn, 0);
    chk("rst_press", o_press, 0);
    chk("rst_release", o_release, 0);
    chk("rst_change", o_change, 0);
    rst_n = 1'b1;
    mon_en = 1;

    // Idle with inputs low, count prescaler ticks
    ticks = 0;
    repeat (48) begin
      @(negedge clk);
      if (dut.tick) ticks++;
    end
    chk("tick_count", ticks, 48 / P);
    repeat (2) @(negedge clk);

    // Clean press on bit 0
    k = n;
    btn[0] = 1'b1;
    wait_bit(0, 1'b1, 60, m);
    chk_range("press0_latency", m - (k + 1), (NT - 1) * P + 2, NT * P + 1);
    repeat (10) @(negedge clk);

    // Bounce on bit 3, then hold high
    for (int seg = 0; seg < 20; seg++) begin
      btn[3] = (seg % 2 == 0);
      repeat (5) @(negedge clk);
    end
    chk("bounce3_held_low", o_btn[3], 0);
    k = n;
    btn[3] = 1'b1;
    wait_bit(3, 1'b1, 60, m);
    chk_range("bounce3_latency", m - (k + 1), (NT - 1) * P + 2, NT * P + 1);
    repeat (10) @(negedge clk);

    // Bits 1 and 6 high, then dropped together
    btn = btn | 8'h42;
    repeat (30) @(negedge clk);
    chk("multi_high", o_btn & 8'h42, 8'h42);
    btn = btn & ~8'h42;
    m = -1;
    for (int c = 0; c < 60 && m < 0; c++) begin
      @(negedge clk);
      if (o_release != '0) m = n;
    end
    chk("multi_release_mask", o_release, 8'h42);
    chk("multi_levels_low", o_btn & 8'h42, 0);
    @(negedge clk);
    chk("multi_release_once", o_release, 0);
    chk("multi_change_once", o_change, 0);

    // Reset in the middle of an interval on bit 2
    btn = '0;
    repeat (30) @(negedge clk);
    btn[2] = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_btn", o_btn, 0);
    chk("async_rst_cnt2", dut.cnt[2], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_bit(2, 1'b1, 60, m);
    chk_range("post_reset_latency", m, (NT - 1) * P + 3, NT * P + 2);
    repeat (10) @(negedge clk);

    // Randomised traffic, each bit toggles with probability 1/16 per cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NIN; i++)
        if ($urandom_range(0, 15) == 0) btn[i] = ~btn[i];
    end
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
